// File: rtl/load_store_unit.sv
// load_store_unit: serialises CPU loads/stores into one byte access per cycle on a byte-wide memory port.
// Optional feature macro: LSU_MISALIGN_TRAP_EN (misaligned requests skip the transfer and return resp_err).
// Ports:
//   clk, reset                       clock and synchronous active-high reset
//   req_valid/req_ready              request handshake from the MEM stage
//   req_write, req_size, req_unsigned, req_addr, req_wdata   request attributes
//   resp_valid, resp_rdata, resp_err one-cycle completion with extended load data
//   mem_addr, mem_wdata, mem_we, mem_re, mem_rdata           byte memory port (combinational read)
module load_store_unit #(
    parameter int ADDR_W = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [63:0]       req_wdata,
    output logic              resp_valid,
    output logic [63:0]       resp_rdata,
    output logic              resp_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              mem_we,
    output logic              mem_re,
    input  logic [7:0]        mem_rdata
);
    typedef enum logic [1:0] {IDLE, XFER, RESP} state_t;
    state_t            state;
    logic [2:0]        cnt, cnt_n, n_m1;
    logic [ADDR_W-1:0] base;
    logic [63:0]       wdata, asm_q, asm_n, ext;
    logic [1:0]        size;
    logic              write, uns, sgn;
    logic              mis;
    assign req_ready = (state == IDLE) && !reset;
    assign cnt_n     = cnt + 3'd1;
    // last byte index N-1 for N = 1/2/4/8
    assign n_m1      = {size == 2'd3, size[1], size != 2'd0};
    // assembly register including the byte read in the current cycle
    always_comb begin
        asm_n = asm_q;
        asm_n[{cnt, 3'b000} +: 8] = mem_rdata;
    end
    always_comb begin
        sgn = 1'b0;
        ext = asm_n;
        if (size == 2'd0) begin
            sgn = !uns && asm_n[7];
            ext = {{56{sgn}}, asm_n[7:0]};
        end else if (size == 2'd1) begin
            sgn = !uns && asm_n[15];
            ext = {{48{sgn}}, asm_n[15:0]};
        end else if (size == 2'd2) begin
            sgn = !uns && asm_n[31];
            ext = {{32{sgn}}, asm_n[31:0]};
        end
    end
`ifdef LSU_MISALIGN_TRAP_EN
    assign mis = (req_size == 2'd1 && req_addr[0]) ||
                 (req_size == 2'd2 && req_addr[1:0] != 2'b00) ||
                 (req_size == 2'd3 && req_addr[2:0] != 3'b000);
    always_ff @(posedge clk) begin
        if (reset)
            resp_err <= 1'b0;
        else
            resp_err <= (state == IDLE) && req_valid && mis;
    end
`else
    assign mis      = 1'b0;
    assign resp_err = 1'b0;
`endif
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= 3'd0;
            resp_valid <= 1'b0;
            resp_rdata <= 64'd0;
            mem_we     <= 1'b0;
            mem_re     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= 8'd0;
            base       <= '0;
            wdata      <= 64'd0;
            asm_q      <= 64'd0;
            size       <= 2'd0;
            write      <= 1'b0;
            uns        <= 1'b0;
        end else begin
            case (state)
                IDLE: if (req_valid) begin
                    base  <= req_addr;
                    wdata <= req_wdata;
                    size  <= req_size;
                    write <= req_write;
                    uns   <= req_unsigned;
                    cnt   <= 3'd0;
                    asm_q <= 64'd0;
                    if (mis) begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                    end else begin
                        state     <= XFER;
                        mem_addr  <= req_addr;
                        mem_wdata <= req_write ? req_wdata[7:0] : 8'd0;
                        mem_we    <= req_write;
                        mem_re    <= !req_write;
                    end
                end
                XFER: begin
                    asm_q <= asm_n;
                    cnt   <= cnt_n;
                    if (cnt == n_m1) begin
                        state      <= RESP;
                        mem_we     <= 1'b0;
                        mem_re     <= 1'b0;
                        mem_addr   <= '0;
                        mem_wdata  <= 8'd0;
                        resp_valid <= 1'b1;
                        resp_rdata <= write ? 64'd0 : ext;
                    end else begin
                        mem_addr  <= base + ADDR_W'(cnt_n);
                        mem_wdata <= write ? wdata[{cnt_n, 3'b000} +: 8] : 8'd0;
                    end
                end
                RESP: begin
                    state      <= IDLE;
                    cnt        <= 3'd0;
                    resp_valid <= 1'b0;
                    resp_rdata <= 64'd0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed and randomized checks of load_store_unit against a byte-array memory model.
module tb_load_store_unit;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [1:0]  req_size = 2'd0;
    logic        req_unsigned = 1'b0;
    logic [63:0] req_addr = 64'd0;
    logic [63:0] req_wdata = 64'd0;
    logic        resp_valid;
    logic [63:0] resp_rdata;
    logic        resp_err;
    logic [63:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_we;
    logic        mem_re;
    logic [7:0]  mem_rdata;
    bit   [7:0]  mem [256];
    bit   [7:0]  ref_mem [256];
    int          vectors = 0;
    int          errs = 0;

    load_store_unit #(.ADDR_W(64)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_err(resp_err), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_we(mem_we), .mem_re(mem_re), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr[7:0]];
    always @(posedge clk) if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] model_load(input logic [63:0] a, input int n, input logic u);
        logic [63:0] v = 64'd0;
        for (int i = 0; i < n; i++) v = v | (64'(ref_mem[8'(a + 64'(i))]) << (8 * i));
        if (!u && n < 8 && v[8 * n - 1]) v = v | (~64'd0 << (8 * n));
        return v;
    endfunction

    task automatic wait_ready();
        for (int i = 0; i < 40 && !req_ready; i++) @(negedge clk);
        chk("ready_wait", 64'(req_ready), 64'd1);
    endtask

    task automatic do_req(input logic w, input logic [1:0] sz, input logic u,
                          input logic [63:0] a, input logic [63:0] d);
        int n;
        bit mis;
        logic [63:0] exp;
        n = 1 << sz;
        mis = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
        mis = (a % 64'(n)) != 64'd0;
`endif
        exp = (w || mis) ? 64'd0 : model_load(a, n, u);
        wait_ready();
        req_valid = 1'b1; req_write = w; req_size = sz; req_unsigned = u;
        req_addr = a; req_wdata = d;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        if (mis) begin
            chk("mis_we", 64'(mem_we), 64'd0);
            chk("mis_re", 64'(mem_re), 64'd0);
            chk("mis_valid", 64'(resp_valid), 64'd1);
            chk("mis_err", 64'(resp_err), 64'd1);
            chk("mis_rdata", resp_rdata, 64'd0);
        end else begin
            for (int k = 0; k < n; k++) begin
                chk("xfer_we", 64'(mem_we), 64'(w));
                chk("xfer_re", 64'(mem_re), 64'(!w));
                chk("xfer_addr", mem_addr, a + 64'(k));
                if (w) chk("xfer_wdata", 64'(mem_wdata), 64'(d[8 * k +: 8]));
                chk("xfer_busy", 64'(req_ready), 64'd0);
                chk("xfer_novalid", 64'(resp_valid), 64'd0);
                @(negedge clk);
            end
            chk("resp_valid", 64'(resp_valid), 64'd1);
            chk("resp_rdata", resp_rdata, exp);
            chk("resp_err", 64'(resp_err), 64'd0);
            chk("resp_we", 64'(mem_we | mem_re), 64'd0);
            chk("resp_busy", 64'(req_ready), 64'd0);
            if (w) for (int k = 0; k < n; k++) ref_mem[8'(a + 64'(k))] = d[8 * k +: 8];
        end
        @(negedge clk);
        chk("ready_back", 64'(req_ready), 64'd1);
        chk("valid_drop", 64'(resp_valid), 64'd0);
    endtask

    initial begin
        // reset state
        @(posedge clk); @(posedge clk);
        @(negedge clk);
        chk("rst_ready", 64'(req_ready), 64'd0);
        chk("rst_valid", 64'(resp_valid), 64'd0);
        chk("rst_err", 64'(resp_err), 64'd0);
        chk("rst_rdata", resp_rdata, 64'd0);
        chk("rst_we", 64'(mem_we), 64'd0);
        chk("rst_re", 64'(mem_re), 64'd0);
        chk("rst_addr", mem_addr, 64'd0);
        chk("rst_wdata", 64'(mem_wdata), 64'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_ready_after", 64'(req_ready), 64'd1);

        // directed: double store/load, sign/zero extension, word sign extension
        do_req(1'b1, 2'd3, 1'b0, 64'd0, 64'h1122334455667788);
        do_req(1'b0, 2'd3, 1'b0, 64'd0, 64'd0);
        chk("dbl_load_const", resp_rdata, 64'd0);
        do_req(1'b1, 2'd0, 1'b0, 64'd16, 64'h80);
        do_req(1'b0, 2'd0, 1'b0, 64'd16, 64'd0);
        do_req(1'b0, 2'd0, 1'b1, 64'd16, 64'd0);
        do_req(1'b1, 2'd2, 1'b0, 64'd20, 64'h80000063);
        do_req(1'b0, 2'd2, 1'b0, 64'd20, 64'd0);
        do_req(1'b0, 2'd2, 1'b1, 64'd20, 64'd0);
        do_req(1'b0, 2'd3, 1'b0, 64'd0, 64'd0);

        // held req_valid: back-to-back half stores
        wait_ready();
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'd1; req_unsigned = 1'b0;
        req_addr = 64'd40; req_wdata = 64'hBEEF;
        @(posedge clk);
        @(negedge clk);
        req_addr = 64'd42; req_wdata = 64'hCAFE;
        chk("b2b_a0", mem_addr, 64'd40);
        chk("b2b_d0", 64'(mem_wdata), 64'hEF);
        @(negedge clk);
        chk("b2b_a1", mem_addr, 64'd41);
        chk("b2b_ready1", 64'(req_ready), 64'd0);
        @(negedge clk);
        chk("b2b_resp", 64'(resp_valid), 64'd1);
        chk("b2b_ready2", 64'(req_ready), 64'd0);
        chk("b2b_idle_we", 64'(mem_we), 64'd0);
        @(negedge clk);
        chk("b2b_ready3", 64'(req_ready), 64'd1);
        chk("b2b_gap_we", 64'(mem_we), 64'd0);
        @(negedge clk);
        req_valid = 1'b0;
        chk("b2b_a2", mem_addr, 64'd42);
        chk("b2b_d2", 64'(mem_wdata), 64'hFE);
        @(negedge clk);
        chk("b2b_a3", mem_addr, 64'd43);
        chk("b2b_d3", 64'(mem_wdata), 64'hCA);
        @(negedge clk);
        chk("b2b_resp2", 64'(resp_valid), 64'd1);
        ref_mem[40] = 8'hEF; ref_mem[41] = 8'hBE; ref_mem[42] = 8'hFE; ref_mem[43] = 8'hCA;
        @(negedge clk);
        do_req(1'b0, 2'd2, 1'b0, 64'd40, 64'd0);

        // reset during the third write cycle of a double store, with a coincident request
        do_req(1'b1, 2'd3, 1'b0, 64'd32, 64'hA0A1A2A3A4A5A6A7);
        wait_ready();
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'd3; req_addr = 64'd32;
        req_wdata = 64'h0102030405060708;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        chk("abort_a0", mem_addr, 64'd32);
        @(negedge clk);
        chk("abort_a1", mem_addr, 64'd33);
        @(negedge clk);
        chk("abort_a2", mem_addr, 64'd34);
        chk("abort_we2", 64'(mem_we), 64'd1);
        reset = 1'b1;
        req_valid = 1'b1; req_write = 1'b0; req_size = 2'd0; req_addr = 64'd8;
        @(negedge clk);
        chk("abort_we", 64'(mem_we), 64'd0);
        chk("abort_valid", 64'(resp_valid), 64'd0);
        chk("abort_ready", 64'(req_ready), 64'd0);
        chk("abort_addr", mem_addr, 64'd0);
        @(negedge clk);
        chk("abort_disc_re", 64'(mem_re), 64'd0);
        reset = 1'b0;
        req_valid = 1'b0;
        @(negedge clk);
        chk("abort_ready_after", 64'(req_ready), 64'd1);
        chk("abort_no_we", 64'(mem_we | mem_re), 64'd0);
        chk("abort_no_valid", 64'(resp_valid), 64'd0);
        ref_mem[32] = 8'h08; ref_mem[33] = 8'h07; ref_mem[34] = 8'h06;
        do_req(1'b0, 2'd3, 1'b0, 64'd32, 64'd0);

        // misaligned word load and address wrap at the top of the space
        do_req(1'b0, 2'd2, 1'b0, 64'd2, 64'd0);
        do_req(1'b1, 2'd2, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 64'h11223344);
        do_req(1'b0, 2'd2, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 64'd0);

        // randomized requests
        for (int i = 0; i < 60; i++) begin
            logic [63:0] a;
            a = {($urandom_range(0, 3) == 0) ? 56'hFF_FFFF_FFFF_FFFF : 56'd0, 8'($urandom)};
            do_req(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   a, {$urandom, $urandom});
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule

// File: doc/load_store_unit.md
# load_store_unit

Initiator side of the byte-wide data-memory port. Accepts one load or store request at a time from the CPU MEM stage and serialises it into one byte access per cycle on the memory port. Loads are reassembled little-endian and sign- or zero-extended to 64 bits. Sits between the pipeline MEM stage and the byte-array data memory, which has a combinational read and a clocked write.

## Interface
Parameters:
- `ADDR_W`, default 64: address width.

Ports:
- `clk` input 1: single clock; all state updates on posedge.
- `reset` input 1: synchronous, active-high.
- `req_valid` input 1: request present.
- `req_ready` output 1: unit can accept a request.
- `req_write` input 1: 1 = store, 0 = load.
- `req_size` input 2: 0 = byte, 1 = half, 2 = word, 3 = double (N = 1/2/4/8 bytes).
- `req_unsigned` input 1: zero-extend the load result; ignored for double and for stores.
- `req_addr` input ADDR_W: byte address.
- `req_wdata` input 64: store data; the low N bytes are used.
- `resp_valid` output 1: one-cycle completion pulse.
- `resp_rdata` output 64: extended load data; 0 for stores.
- `resp_err` output 1: misaligned request (only meaningful with `LSU_MISALIGN_TRAP_EN`).
- `mem_addr` output ADDR_W: byte address to memory.
- `mem_wdata` output 8: byte to write.
- `mem_we` output 1: byte write strobe, sampled by memory on posedge.
- `mem_re` output 1: byte read enable.
- `mem_rdata` input 8: combinational read byte at `mem_addr`.

## Operation
- FSM states:
  - IDLE: `req_ready` = 1.
  - XFER: byte counter `cnt` runs 0..N-1.
  - RESP: `resp_valid` = 1.
- Accept: on a posedge with state IDLE and `req_valid` = 1. At that edge, latch addr, wdata, size, write and unsigned, clear `cnt` and the assembly register, and go to XFER.
- XFER, each cycle:
  - `mem_addr` = base + `cnt`, computed modulo 2^ADDR_W, so the address wraps at the top of the address space.
  - Store: `mem_we` = 1, `mem_wdata` = wdata[8·cnt+7 : 8·cnt].
  - Load: `mem_re` = 1, and `mem_rdata` is captured into byte `cnt` of the assembly register at the posedge.
  - `cnt` increments each cycle. When `cnt` = N-1, the next state is RESP.
- RESP:
  - `resp_valid` = 1 for exactly one cycle.
  - `resp_rdata` is the assembled value. Bit 8N-1 is replicated into the upper bits, unless `req_unsigned` is set or N = 8.
  - Next state is IDLE.
- `req_ready` is 0 in XFER and RESP; a request presented then is not accepted and must be held by the requester.
- Outside XFER, `mem_we` and `mem_re` are 0. `mem_addr`, `mem_wdata`, `resp_rdata` and `resp_err` are 0 outside their active state.
- Reset values: state IDLE, `resp_valid` 0, `resp_err` 0, `resp_rdata` 0, `mem_we` 0, `mem_re` 0, `mem_addr` 0, `mem_wdata` 0, `cnt` 0. `req_ready` is forced to 0 while `reset` is high.
- Reset mid-operation: the transfer is aborted at that edge and no further `mem_we` is issued. Bytes already written stay written, and no `resp_valid` is produced.
- A request coincident with a `reset` edge is discarded.

## Timing
- Acceptance edge = T0.
- XFER occupies cycles T0+1 .. T0+N.
- `resp_valid` is high in cycle T0+N+1.
- `req_ready` is high again in cycle T0+N+2, so the next request can be accepted at the end of that cycle.
- Latency: byte = 2, half = 3, word = 5, double = 9 cycles from acceptance to `resp_valid`.
- Throughput: one request per N+2 cycles.

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined:
  - A request is misaligned when it is half with `addr[0]` ≠ 0, word with `addr[1:0]` ≠ 0, or double with `addr[2:0]` ≠ 0.
  - A misaligned request skips XFER entirely: no `mem_we`/`mem_re`. It goes IDLE→RESP and produces `resp_valid` = 1, `resp_err` = 1, `resp_rdata` = 0 one cycle after acceptance.
- Not defined:
  - `resp_err` is tied to 0.
  - Misaligned requests are transferred byte-wise like aligned ones.

## Test plan
- Reset, then store double 0x1122334455667788 at addr 0: eight `mem_we` cycles writing bytes 88,77,...,11 to addrs 0..7. `resp_valid` appears at T0+9 with `resp_rdata` = 0.
- Load double from addr 0 after that store: `resp_rdata` = 0x1122334455667788 at T0+9.
- Load byte 0x80 at addr 16 with `req_unsigned` = 0, giving 0xFFFFFFFFFFFFFF80. Repeat with `req_unsigned` = 1, giving 0x0000000000000080. Word load of 0x8000_0063 with `req_unsigned` = 0 gives 0xFFFFFFFF80000063.
- Hold `req_valid` high for back-to-back half stores: second acceptance occurs only after `req_ready` returns in cycle T0+4 (N+2 = 4 cycles after the first acceptance). No overlap on the memory port.
- Assert `reset` during cycle 3 of a double store: bytes 0..2 are written, no further `mem_we`, no `resp_valid`, and `req_ready` = 1 in the cycle after `reset` drops.
- With `LSU_MISALIGN_TRAP_EN`: word load at addr 2 gives `resp_err` = 1 at T0+1 with no `mem_re`. Without the macro, the same load reads addrs 2..5 and `resp_err` = 0.
